// File: rtl/qspi_master.sv
// qspi_master: SPI/QSPI bus initiator, mode 0, 1/2/4-lane byte transfers.
// Byte-level valid/ready request side, one-cycle rx byte strobe.
// Build option: define QSPI_MASTER_DUAL_EN to enable the 2-lane datapath;
// without it tx_mode=2 runs as a single-lane transfer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS high, ready for a new CS window
// SETUP | CS low, spi_clk low, setup time before the first low phase
// LOW   | spi_clk low, lanes present the next bit group
// HIGH  | spi_clk high, lanes sampled on entry, shift on exit
// GAP   | byte done, CS held low, waiting for next byte or going to HOLD
// HOLD  | CS hold time after the final byte
// RECOV | CS high, minimum deselect time before IDLE

module qspi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic [2:0] tx_mode,
    input  logic       tx_dir,
    input  logic       tx_last,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_clk,
    output logic [3:0] spi_data_out,
    output logic [3:0] spi_data_oe,
    input  logic [3:0] spi_data_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_GAP, S_HOLD, S_RECOV
    } state_t;

    typedef enum logic [1:0] {L_ONE, L_TWO, L_FOUR} lanes_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           cnt_tc;
    logic [2:0]     edge_cnt;
    logic           edge_tc;
    logic [7:0]     tx_sh;
    logic [7:0]     rx_sh;
    lanes_t         lanes_q;
    lanes_t         acc_lanes;
    logic           dir_q;
    logic           last_q;
    logic           accept;
    logic           cs_active;

    function automatic lanes_t decode_mode(input logic [2:0] m);
`ifdef QSPI_MASTER_DUAL_EN
        case (m)
            3'd2:    return L_TWO;
            3'd4:    return L_FOUR;
            default: return L_ONE;
        endcase
`else
        // No dual datapath: mode 2 falls back to single lane.
        case (m)
            3'd4:    return L_FOUR;
            default: return L_ONE;
        endcase
`endif
    endfunction

    // Edge counter load value: rising edges per byte minus one.
    function automatic logic [2:0] edges_m1(input lanes_t l);
        case (l)
            L_TWO:   return 3'd3;
            L_FOUR:  return 3'd1;
            default: return 3'd7;
        endcase
    endfunction

    assign acc_lanes = decode_mode(tx_mode);
    assign accept    = tx_valid && tx_ready;
    assign cnt_tc    = (cnt == '0);
    assign edge_tc   = (edge_cnt == 3'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; GAP waits indefinitely for the next byte while CS stays low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: if (cnt_tc) state_nxt = S_LOW;
            S_LOW:   if (cnt_tc) state_nxt = S_HIGH;
            S_HIGH:  if (cnt_tc) state_nxt = edge_tc ? S_GAP : S_LOW;
            S_GAP: begin
                if (last_q)      state_nxt = S_HOLD;
                else if (accept) state_nxt = S_LOW;
            end
            S_HOLD:  if (cnt_tc) state_nxt = S_RECOV;
            S_RECOV: if (cnt_tc) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase timer, edge counter, shift registers and the rx byte strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            edge_cnt  <= 3'd0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            lanes_q   <= L_ONE;
            dir_q     <= 1'b0;
            last_q    <= 1'b0;
            rx_data   <= 8'h00;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;

            if (state_nxt != state) cnt <= CNT_LOAD;
            else if (!cnt_tc)       cnt <= cnt - 1'b1;

            if (accept) begin
                lanes_q  <= acc_lanes;
                // Single lane is always full duplex, so it always drives.
                dir_q    <= (acc_lanes == L_ONE) ? 1'b1 : tx_dir;
                last_q   <= tx_last;
                tx_sh    <= ((acc_lanes == L_ONE) || tx_dir) ? tx_data : 8'h00;
                edge_cnt <= edges_m1(acc_lanes);
                rx_sh    <= 8'h00;
            end

            if ((state == S_LOW) && cnt_tc) begin
                case (lanes_q)
                    L_TWO:   rx_sh <= {rx_sh[5:0], spi_data_in[1:0]};
                    L_FOUR:  rx_sh <= {rx_sh[3:0], spi_data_in};
                    default: rx_sh <= {rx_sh[6:0], spi_data_in[1]};
                endcase
            end

            if ((state == S_HIGH) && cnt_tc) begin
                case (lanes_q)
                    L_TWO:   tx_sh <= {tx_sh[5:0], 2'b00};
                    L_FOUR:  tx_sh <= {tx_sh[3:0], 4'h0};
                    default: tx_sh <= {tx_sh[6:0], 1'b0};
                endcase
                if (edge_tc) begin
                    rx_data   <= rx_sh;
                    rx_strobe <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt - 1'b1;
                end
            end
        end
    end

    // Bus outputs and handshake, decoded from state and latched byte settings.
    always_comb begin
        cs_active    = (state == S_SETUP) || (state == S_LOW) || (state == S_HIGH) ||
                       (state == S_GAP)   || (state == S_HOLD);
        tx_ready     = !reset && ((state == S_IDLE) || ((state == S_GAP) && !last_q));
        busy         = (state != S_IDLE);
        spi_cs       = !cs_active;
        spi_clk      = (state == S_HIGH);
        spi_data_out = 4'h0;
        spi_data_oe  = 4'h0;
        if (cs_active) begin
            case (lanes_q)
                L_TWO: begin
                    spi_data_oe = {2'b00, {2{dir_q}}};
                    if (dir_q) spi_data_out = {2'b00, tx_sh[7:6]};
                end
                L_FOUR: begin
                    spi_data_oe = {4{dir_q}};
                    if (dir_q) spi_data_out = tx_sh[7:4];
                end
                default: begin
                    spi_data_oe  = 4'b0001;
                    spi_data_out = {3'b000, tx_sh[7]};
                end
            endcase
        end
    end

endmodule
